// File: rtl/qft_pkg.sv
// Shared types and helpers for the QFT read-out path.
// Provides the state enum and the complex-element field/squaring helpers.
package qft_pkg;

  localparam int MAX_DW = 64;

  typedef logic [2*MAX_DW-1:0] cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Fields are placed at the top of the word and then
  // arithmetic-shifted down, so the result is sign-extended.
  function automatic logic signed [MAX_DW-1:0] cplx_re(
    input cplx_t e,
    input int    dw
  );
    logic signed [2*MAX_DW-1:0] t;
    t = e << (2*MAX_DW - 2*dw);
    t = t >>> (2*MAX_DW - dw);
    return t[MAX_DW-1:0];
  endfunction

  function automatic logic signed [MAX_DW-1:0] cplx_im(
    input cplx_t e,
    input int    dw
  );
    logic signed [2*MAX_DW-1:0] t;
    t = e << (2*MAX_DW - dw);
    t = t >>> (2*MAX_DW - dw);
    return t[MAX_DW-1:0];
  endfunction

  function automatic cplx_t cplx_sq(
    input logic signed [MAX_DW-1:0] v
  );
    return (2*MAX_DW)'(v * v);
  endfunction

endpackage

// File: rtl/qft_result_reader_cmag2.sv
// cmag2: exact squared magnitude of one {re, im} element.
// Ports: elem (2*DATA_W, {re,im}) in; mag2 (2*DATA_W+1, unsigned) out.
module cmag2
  import qft_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] elem,
  output logic [2*DATA_W:0]   mag2
);

  cplx_t ext;

  always_comb begin
    ext  = (2*MAX_DW)'(elem);
    mag2 = (2*DATA_W+1)'(
      cplx_sq(cplx_re(ext, DATA_W)) +
      cplx_sq(cplx_im(ext, DATA_W)));
  end

endmodule

// File: rtl/qft_result_reader.sv
// qft_result_reader: snapshots S_amp on capture and streams it out.
// Ports: clk, rst (async low), S_amp, capture, m_ready in;
// m_valid, m_data, m_prob, m_idx, m_last, busy, capture_err out.
module qft_result_reader
  import qft_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int SEL_W  = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0][2*DATA_W-1:0]     S_amp,
  input  logic                           capture,
  input  logic                           m_ready,
  output logic                           m_valid,
  output logic [2*DATA_W-1:0]            m_data,
  output logic [2*DATA_W:0]              m_prob,
  output logic [SEL_W-1:0]               m_idx,
  output logic                           m_last,
  output logic                           busy,
  output logic                           capture_err
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N-1);

  state_t                      state_q;
  state_t                      state_d;
  logic [N-1:0][2*DATA_W-1:0]  snap;
  logic                        xfer;
  logic                        at_last;
  logic                        fin;
  logic                        cap_ok;
  logic [SEL_W-1:0]            idx_nxt;
  logic [2*DATA_W-1:0]         sel_elem;
  logic [2*DATA_W:0]           sel_mag;

  always_comb begin
    m_valid = (state_q == STREAM);
    busy    = (state_q != IDLE);
    m_last  = m_valid & (m_idx == LAST_IDX);
  end

  always_comb begin
    xfer    = m_valid & m_ready;
    at_last = (m_idx == LAST_IDX);
    fin     = xfer & at_last;
    cap_ok  = capture & ((state_q == IDLE) | fin);
    idx_nxt = m_idx + 1'b1;
    // A fresh capture presents live element 0; the snapshot
    // is being written on the same edge.
    sel_elem = cap_ok ? S_amp[0] : snap[idx_nxt];
  end

  cmag2 #(
    .DATA_W (DATA_W)
  ) u_cmag2 (
    .elem (sel_elem),
    .mag2 (sel_mag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cap_ok) state_d = STREAM;
      STREAM: if (fin && !cap_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap        <= '0;
      m_idx       <= '0;
      m_data      <= '0;
      m_prob      <= '0;
      capture_err <= 1'b0;
    end else begin
      capture_err <= capture & ~cap_ok;
      if (cap_ok) begin
        snap   <= S_amp;
        m_idx  <= '0;
        m_data <= sel_elem;
        m_prob <= sel_mag;
      end else if (xfer && !at_last) begin
        m_idx  <= idx_nxt;
        m_data <= sel_elem;
        m_prob <= sel_mag;
      end
    end
  end

endmodule
